mulu_m3q3_seq: RTL and testbench

MULU_M3Q3_SEQ -- requirements
Module: mulu_m3q3_seq

---
 rtl/mulu_m3q3_seq.sv | 138 +++++++++++++
 tb/tb_mulu_m3q3_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mulu_m3q3_seq.sv
// Sequential 3x3 unsigned multiply wrapper: registers operands for an external multiplier and
// buffers products in a 2-entry FIFO. Define MULU_SEQ_COUNT_EN to add the op_count port.
module mulu_m3q3_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_x,
  input  logic [2:0] in_y,
  output logic [2:0] mul_x,
  output logic [2:0] mul_y,
  input  logic [5:0] mul_p,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_p
`ifdef MULU_SEQ_COUNT_EN
  ,
  output logic [7:0] op_count
`endif
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t     state_q, state_d;
  logic [1:0] count_q, count_d;
  logic [5:0] head_q, head_d;
  logic [5:0] tail_q, tail_d;
  logic [2:0] mul_x_q, mul_x_d;
  logic [2:0] mul_y_q, mul_y_d;
  logic       accept;
  logic       push;
  logic       pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready depends on registers only, so there is no combinational path from in_valid/out_ready
  always_comb begin
    in_ready  = (state_q == IDLE) && (count_q < 2'd2);
    out_valid = (count_q != 2'd0);
    out_p     = out_valid ? head_q : 6'd0;
    mul_x     = mul_x_q;
    mul_y     = mul_y_q;
  end

  assign accept = in_valid && in_ready;
  assign push   = (state_q == CALC);
  assign pop    = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    mul_x_d = mul_x_q;
    mul_y_d = mul_y_q;
    if (accept) begin
      mul_x_d = in_x;
      mul_y_d = in_y;
    end
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = mul_p;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          tail_d  = mul_p;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        head_d  = tail_q;
        tail_d  = 6'd0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // count is unchanged; the old head leaves and the new product joins behind any survivor
        if (count_q == 2'd1) begin
          head_d = mul_p;
        end else begin
          head_d = tail_q;
          tail_d = mul_p;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= 6'd0;
      tail_q  <= 6'd0;
      mul_x_q <= 3'd0;
      mul_y_q <= 3'd0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      mul_x_q <= mul_x_d;
      mul_y_q <= mul_y_d;
    end
  end

`ifdef MULU_SEQ_COUNT_EN
  logic [7:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (push) op_count_d = op_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 8'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mulu_m3q3_seq.sv
// Self-checking bench for mulu_m3q3_seq: directed and exhaustive stimulus against a queue-based
// reference model. Define MULU_SEQ_COUNT_EN to also check op_count.
module tb_mulu_m3q3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_x;
  logic [2:0] in_y;
  logic [2:0] mul_x;
  logic [2:0] mul_y;
  logic [5:0] mul_p;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_p;
`ifdef MULU_SEQ_COUNT_EN
  logic [7:0] op_count;
`endif

  int tests = 0;
  int fails = 0;

  // reference model: queue of buffered products plus one product in flight
  int m_q[$];
  bit m_pend;
  int m_pend_val;
  int m_x;
  int m_y;
  int m_cnt;
  bit m_acc;
  int dut_pops;

  always #5 clk = ~clk;

  // the external combinational multiplier
  assign mul_p = mul_x * mul_y;

  mulu_m3q3_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
`ifdef MULU_SEQ_COUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  function automatic bit model_ready();
    return !m_pend && (m_q.size() < 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, advance the model across the edge, then check every output
  task automatic applyStimulus(input bit r, input bit v, input int x, input int y, input bit ordy);
    bit pop;
    bit push;
    int push_val;
    int exp_p;
    rst       = r;
    in_valid  = v;
    in_x      = x[2:0];
    in_y      = y[2:0];
    out_ready = ordy;
    if (!r && out_valid === 1'b1 && ordy) dut_pops++;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_pend = 1'b0;
      m_x    = 0;
      m_y    = 0;
      m_cnt  = 0;
      m_acc  = 1'b0;
    end else begin
      m_acc    = v && model_ready();
      pop      = (m_q.size() != 0) && ordy;
      push     = m_pend;
      push_val = m_pend_val;
      if (push && !pop && m_q.size() == 2) begin
        fails++;
        $error("[TB] FAIL push_full: observed push at count 2 expected none");
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(push_val);
        m_cnt = (m_cnt + 1) % 256;
      end
      m_pend = m_acc;
      if (m_acc) begin
        m_pend_val = x * y;
        m_x        = x;
        m_y        = y;
      end
    end
    #1;
    exp_p = (m_q.size() != 0) ? m_q[0] : 0;
    checkOutput("in_ready", 8'(in_ready), 8'(model_ready()));
    checkOutput("out_valid", 8'(out_valid), 8'(m_q.size() != 0));
    checkOutput("out_p", 8'(out_p), 8'(exp_p));
    checkOutput("mul_x", 8'(mul_x), 8'(m_x));
    checkOutput("mul_y", 8'(mul_y), 8'(m_y));
`ifdef MULU_SEQ_COUNT_EN
    checkOutput("op_count", op_count, 8'(m_cnt));
`endif
  endtask

  initial begin
    int budget;

    // reset
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 7, 7, 1);
    checkOutput("rst_in_ready", 8'(in_ready), 8'd1);
    checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
    checkOutput("rst_out_p", 8'(out_p), 8'd0);

    // 3x5 with out_ready held high
    applyStimulus(0, 1, 3, 5, 1);
    checkOutput("t24_calc_ready", 8'(in_ready), 8'd0);
    checkOutput("t24_mul_x", 8'(mul_x), 8'd3);
    checkOutput("t24_mul_y", 8'(mul_y), 8'd5);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t24_valid", 8'(out_valid), 8'd1);
    checkOutput("t24_p", 8'(out_p), 8'd15);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t24_popped", 8'(out_valid), 8'd0);

    // fill the buffer with out_ready low, then drain
    applyStimulus(0, 1, 7, 7, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t25_p49", 8'(out_p), 8'd49);
    applyStimulus(0, 1, 2, 3, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t25_full_ready", 8'(in_ready), 8'd0);
    checkOutput("t25_hold49", 8'(out_p), 8'd49);
    applyStimulus(0, 1, 5, 5, 0);
    applyStimulus(0, 1, 5, 5, 0);
    checkOutput("t25_no_accept_x", 8'(mul_x), 8'd2);
    checkOutput("t25_still_full", 8'(in_ready), 8'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t25_second", 8'(out_p), 8'd6);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t25_empty", 8'(out_valid), 8'd0);

    // push and pop on the same CALC edge
    applyStimulus(0, 1, 2, 2, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("t26_head4", 8'(out_p), 8'd4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t26_valid", 8'(out_valid), 8'd1);
    checkOutput("t26_head1", 8'(out_p), 8'd1);
    checkOutput("t26_ready", 8'(in_ready), 8'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t26_drained", 8'(out_valid), 8'd0);

    // reset while a 7x7 is in CALC
    applyStimulus(0, 1, 7, 7, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("t27_valid", 8'(out_valid), 8'd0);
    checkOutput("t27_ready", 8'(in_ready), 8'd1);
    checkOutput("t27_mul_x", 8'(mul_x), 8'd0);
    checkOutput("t27_mul_y", 8'(mul_y), 8'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("t27_no49", 8'(out_valid), 8'd0);
    end

    // every operand pair, random back-pressure
    applyStimulus(1, 0, 0, 0, 0);
    dut_pops = 0;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        budget = 0;
        do begin
          applyStimulus(0, 1, x, y, 1'($urandom_range(0, 1)));
          budget++;
        end while (!m_acc && budget < 200);
        if (!m_acc) begin
          fails++;
          $error("[TB] FAIL exh_timeout: observed no accept expected accept of %0d x %0d", x, y);
        end
      end
    end
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("exh_pops", 8'(dut_pops), 8'd64);

`ifdef MULU_SEQ_COUNT_EN
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 257; i++) begin
      applyStimulus(0, 1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 1);
    end
    checkOutput("cnt_257", op_count, 8'd1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("cnt_reset", op_count, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
